pipe_skid_stage: RTL and testbench

Parametrised pipeline inter-stage register. It supersedes the single-register load/stall/flush stage with a valid/ready handshake and a 2-entry skid buffer. Upstream can therefore stream at one beat per cycle while downstream stalls, with no combinational ready path from output to input. It sits between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It adds a flush that discards in-flight beats and a saturating discarded-beat counter for hazard/perf debug.

---
 rtl/pipe_skid_stage.sv | 100 ++++++++++
 tb/tb_pipe_skid_stage.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// Pipeline inter-stage register with a valid/ready handshake and a 2-entry skid buffer.
// Adds a flush that discards held beats and a saturating count of the beats it drops.
module pipe_skid_stage #(
  parameter int WIDTH          = 32,
  parameter int CNT_W          = 8,
  parameter bit CLEAR_ON_FLUSH = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] drop_count
);

  // The state encoding equals the number of beats held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int SUM_W = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_reg;
  logic [WIDTH-1:0] main_reg;
  logic [WIDTH-1:0] skid_reg;
  logic [CNT_W-1:0] drop_reg;

  logic             in_fire;
  logic             out_fire;
  logic [SUM_W-1:0] drop_sum;
  logic [CNT_W-1:0] drop_next;

  // Ready depends only on registered state (plus flush), never on out_ready.
  assign in_ready   = (state_reg != FULL) & ~flush;
  assign out_valid  = (state_reg != EMPTY) & ~flush;
  assign in_fire    = in_valid & in_ready;
  assign out_fire   = out_valid & out_ready;
  assign out_data   = main_reg;
  assign occupancy  = state_reg;
  assign drop_count = drop_reg;

  always_comb begin
    drop_sum  = SUM_W'(drop_reg) + SUM_W'(state_reg);
    drop_next = (drop_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= EMPTY;
      drop_reg  <= '0;
      if (CLEAR_ON_FLUSH) begin
        main_reg <= '0;
        skid_reg <= '0;
      end
    end else if (flush) begin
      state_reg <= EMPTY;
      drop_reg  <= drop_next;
      if (CLEAR_ON_FLUSH) begin
        main_reg <= '0;
        skid_reg <= '0;
      end
    end else begin
      case (state_reg)
        EMPTY: begin
          if (in_fire) begin
            main_reg  <= in_data;
            state_reg <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_reg <= in_data;
          end else if (in_fire) begin
            skid_reg  <= in_data;
            state_reg <= FULL;
          end else if (out_fire) begin
            state_reg <= EMPTY;
          end
        end
        FULL: begin
          // The skid beat moves up behind the delivered main beat.
          if (out_fire) begin
            main_reg  <= skid_reg;
            state_reg <= ONE;
          end
        end
        default: state_reg <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: reset, streaming, skid backpressure, flush and counter saturation.
// A second instance with a 2-bit counter is driven in parallel to exercise saturation.
module tb_pipe_skid_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = '0;

  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [1:0]  occupancy;
  logic [7:0]  drop_count;

  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_data;
  logic [1:0]  s_occupancy;
  logic [1:0]  s_drop_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(.WIDTH(32), .CNT_W(8), .CLEAR_ON_FLUSH(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .drop_count(drop_count)
  );

  pipe_skid_stage #(.WIDTH(32), .CNT_W(2), .CLEAR_ON_FLUSH(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .occupancy(s_occupancy), .drop_count(s_drop_count)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end else begin
      $display("ok   %s: 0x%0h", tag, observed);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] a, input logic [31:0] b);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = a;
    tick();
    in_data   = b;
    tick();
    in_valid  = 1'b0;
    #1;
  endtask

  task automatic flush_cycle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
  endtask

  logic [31:0] stream_vec [3];

  initial begin
    stream_vec[0] = 32'h11;
    stream_vec[1] = 32'h22;
    stream_vec[2] = 32'h33;

    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;

    // Reset while FULL, with concurrent handshake activity.
    fill(32'h5, 32'h6);
    check("pre_reset_occ", occupancy, 2);
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 32'h7;
    tick();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_occ", occupancy, 0);
    check("rst_drop", drop_count, 0);
    check("rst_out_data", out_data, 0);
    check("rst_sat_drop", s_drop_count, 0);

    // Streaming at one beat per cycle.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = stream_vec[i];
      tick();
      check($sformatf("stream_data%0d", i), out_data, stream_vec[i]);
      check($sformatf("stream_occ%0d", i), occupancy, 1);
      check($sformatf("stream_rdy%0d", i), in_ready, 1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drain_occ", occupancy, 0);
    check("stream_drain_valid", out_valid, 0);

    // Backpressure into the skid register.
    fill(32'hA, 32'hB);
    check("skid_occ", occupancy, 2);
    check("skid_in_ready", in_ready, 0);
    check("skid_out_valid", out_valid, 1);
    check("skid_out_data", out_data, 32'hA);
    tick();
    check("skid_stall_data", out_data, 32'hA);
    out_ready = 1'b1;
    #1;
    check("skid_deliver_a", out_data, 32'hA);
    tick();
    check("skid_deliver_b", out_data, 32'hB);
    check("skid_occ1", occupancy, 1);
    tick();
    check("skid_occ0", occupancy, 0);
    out_ready = 1'b0;

    // Flush while FULL with a competing input beat.
    fill(32'hA, 32'hB);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hC; out_ready = 1'b1;
    #1;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("flush_occ", occupancy, 0);
    check("flush_drop", drop_count, 2);
    check("flush_out_data", out_data, 0);
    check("flush_sat_drop", s_drop_count, 2);
    tick();
    check("flush_no_c", out_valid, 0);
    out_ready = 1'b0;

    // Counter saturation on the 2-bit instance.
    fill(32'h1, 32'h2);
    flush_cycle();
    check("sat2_drop", drop_count, 4);
    check("sat2_sat_drop", s_drop_count, 3);
    fill(32'h3, 32'h4);
    flush_cycle();
    check("sat3_drop", drop_count, 6);
    check("sat3_sat_drop", s_drop_count, 3);

    // Flush while EMPTY leaves the counter alone and the next beat is accepted.
    flush_cycle();
    check("eflush_drop", drop_count, 6);
    check("eflush_sat_drop", s_drop_count, 3);
    in_valid = 1'b1; in_data = 32'hD;
    #1;
    check("eflush_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("eflush_out_valid", out_valid, 1);
    check("eflush_out_data", out_data, 32'hD);
    check("eflush_occ", occupancy, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
